// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART receive types and constants.
//   UART_START_BIT / UART_STOP_BIT : line levels of the framing bits
//   uart_data_t                    : one data character, right-aligned
//   uart_rx_state_t                : receiver FSM states
//   legal_data_bits()              : frame length check (5..8 data bits)
package uart_rx_pkg;

    localparam logic UART_START_BIT     = 1'b0;
    localparam logic UART_STOP_BIT      = 1'b1;
    localparam int   UART_MIN_DATA_BITS = 5;
    localparam int   UART_MAX_DATA_BITS = 8;

    typedef logic [7:0] uart_data_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    function automatic logic legal_data_bits(input logic [3:0] n);
        return (n >= 4'(UART_MIN_DATA_BITS)) && (n <= 4'(UART_MAX_DATA_BITS));
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: config and result bundle between the UART CSR block and uart_rx.
//   baud_count, data_bits, parity_en, odd_parity : frame format (CSR -> receiver)
//   rx_data, rx_valid, parity_error, frame_error,
//   rx_busy                                      : frame results (receiver -> CSR)
//   master modport: CSR side.  slave modport: receiver side.
interface uart_rx_if #(
    parameter int BAUD_WIDTH = 32
);
    import uart_rx_pkg::*;

    logic [BAUD_WIDTH-1:0] baud_count;
    logic [3:0]            data_bits;
    logic                  parity_en;
    logic                  odd_parity;
    uart_data_t            rx_data;
    logic                  rx_valid;
    logic                  parity_error;
    logic                  frame_error;
    logic                  rx_busy;

    modport master (
        output baud_count, data_bits, parity_en, odd_parity,
        input  rx_data, rx_valid, parity_error, frame_error, rx_busy
    );

    modport slave (
        input  baud_count, data_bits, parity_en, odd_parity,
        output rx_data, rx_valid, parity_error, frame_error, rx_busy
    );

endinterface

// File: rtl/uart_rx_sync_edge.sv
// uart_rx_sync_edge: synchronizes the async rx pin and flags its falling edge.
//   clk, rst : clock, synchronous active-high reset
//   rx       : async serial line, idle high
//   rx_s     : rx after SYNC_STAGES flops
//   fall     : rx_s low while the previous rx_s was high
// All flops reset to 1 (idle line) so leaving reset never fakes a start edge.
module uart_rx_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rx_s = sync[SYNC_STAGES-1];
    assign fall = ~rx_s & prev;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 5-8 data bits LSB-first, optional parity, one stop bit.
//   clk, rst : clock, synchronous active-high reset
//   rx       : async serial line, idle high
//   bus      : uart_rx_if.slave -- format config in, rx_data / rx_valid /
//              parity_error / frame_error / rx_busy out
// Cycle 0 is the start-detect cycle. With B = max(baud_count, 2) and H = B>>1,
// samples land on cycle H (start) and H+k*B (data, parity, stop); rx_valid is
// registered one cycle after the stop sample.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int BAUD_WIDTH  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    uart_rx_if.slave    bus
);

    logic rx_s;
    logic fall;

    uart_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    uart_rx_state_t        state;
    logic [BAUD_WIDTH-1:0] bit_len;   // latched, clamped to >= 2
    logic [15:0]           cnt;       // cycles since last sample (or start detect)
    logic [3:0]            bit_idx;
    logic [3:0]            n_bits;
    logic                  par_en_q;
    logic                  odd_q;
    logic                  par_bit;
    uart_data_t            shreg;

    uart_data_t rx_data_q;
    logic       rx_valid_q;
    logic       parity_error_q;
    logic       frame_error_q;
    logic       rx_busy_q;

    logic       hit_half;
    logic       hit_bit;
    uart_data_t aligned;
    logic       par_exp;

    // cnt is 0 on cycle 1, so sampling on cnt == H-1 lands on cycle H.
    assign hit_half = (BAUD_WIDTH'(cnt) == (bit_len >> 1) - BAUD_WIDTH'(1));
    assign hit_bit  = (BAUD_WIDTH'(cnt) == bit_len - BAUD_WIDTH'(1));

    // Bits enter at the MSB; after N shifts the frame sits in the top N bits.
    assign aligned = shreg >> (4'd8 - n_bits);
    assign par_exp = ^aligned ^ odd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bit_len        <= '0;
            cnt            <= '0;
            bit_idx        <= '0;
            n_bits         <= '0;
            par_en_q       <= 1'b0;
            odd_q          <= 1'b0;
            par_bit        <= 1'b0;
            shreg          <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
            rx_busy_q      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            cnt        <= cnt + 16'd1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    // Illegal lengths leave the frame unclaimed.
                    if (fall && legal_data_bits(bus.data_bits)) begin
                        bit_len   <= (bus.baud_count < BAUD_WIDTH'(2)) ? BAUD_WIDTH'(2)
                                                                       : bus.baud_count;
                        n_bits    <= bus.data_bits;
                        par_en_q  <= bus.parity_en;
                        odd_q     <= bus.odd_parity;
                        shreg     <= '0;
                        rx_busy_q <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (hit_half) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (rx_s != UART_START_BIT) begin
                            // Start bit vanished before mid-bit: glitch.
                            rx_busy_q <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (hit_bit) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 4'd1;
                        if (bit_idx == n_bits - 4'd1)
                            state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (hit_bit) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (hit_bit) begin
                        cnt            <= '0;
                        rx_valid_q     <= 1'b1;
                        rx_data_q      <= aligned;
                        parity_error_q <= par_en_q & (par_bit != par_exp);
                        frame_error_q  <= (rx_s != UART_STOP_BIT);
                        rx_busy_q      <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    rx_busy_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.rx_data      = rx_data_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.parity_error = parity_error_q;
    assign bus.frame_error  = frame_error_q;
    assign bus.rx_busy      = rx_busy_q;

endmodule
